// File: rtl/parking_gate_if.sv
// parking_gate_if: loop-detector, vacancy and counter-event bundle
// shared by the gate sequencer (slave) and its driver (master).
interface parking_gate_if #(
  parameter int QUEUE_DEPTH = 8
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          arrive;
  logic          arrive_uni;
  logic          leave;
  logic          leave_uni;
  logic          uni_is_vacated_space;
  logic          is_vacated_space;
  logic          car_entered;
  logic          is_uni_car_enterd;
  logic          car_exited;
  logic          is_uni_car_exited;
  logic          entry_gate_open;
  logic          exit_gate_open;
  logic [CW-1:0] queue_count;
  logic          queue_full;
  logic          arrive_drop;
  logic          exit_drop;
  logic          rejected;

  modport master (
    output arrive,
    output arrive_uni,
    output leave,
    output leave_uni,
    output uni_is_vacated_space,
    output is_vacated_space,
    input  car_entered,
    input  is_uni_car_enterd,
    input  car_exited,
    input  is_uni_car_exited,
    input  entry_gate_open,
    input  exit_gate_open,
    input  queue_count,
    input  queue_full,
    input  arrive_drop,
    input  exit_drop,
    input  rejected
  );

  modport slave (
    input  arrive,
    input  arrive_uni,
    input  leave,
    input  leave_uni,
    input  uni_is_vacated_space,
    input  is_vacated_space,
    output car_entered,
    output is_uni_car_enterd,
    output car_exited,
    output is_uni_car_exited,
    output entry_gate_open,
    output exit_gate_open,
    output queue_count,
    output queue_full,
    output arrive_drop,
    output exit_drop,
    output rejected
  );
endinterface

// File: rtl/parking_gate.sv
// parking_gate: ordered entry queue plus entry/exit barrier sequencers.
// Optional macro PARKING_GATE_REJECT_EN: discard an ineligible head.
module parking_gate #(
  parameter int QUEUE_DEPTH = 8,
  parameter int OPEN_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  parking_gate_if.slave bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(OPEN_CYCLES + 1);
  localparam logic [DW-1:0] DWELL = DW'(OPEN_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_OPEN
  } state_t;

  logic [QUEUE_DEPTH-1:0] r_q;
  logic [AW-1:0]          r_wp;
  logic [AW-1:0]          r_rp;
  logic [CW-1:0]          r_cnt;
  logic                   r_adrop;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head;
  logic                   w_ok;
  logic                   w_empty;

  assign w_empty = (r_cnt == '0);
  // push sees the pre-edge count, so a same-cycle pop frees nothing
  assign w_push  = bus.arrive && (r_cnt != FULL);
  assign w_head  = r_q[r_rp];
  assign w_ok    = w_head ? bus.uni_is_vacated_space
                          : bus.is_vacated_space;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_adrop <= 1'b0;
    end else begin
      r_adrop <= bus.arrive && !w_push;
      if (w_push) begin
        r_q[r_wp] <= bus.arrive_uni;
        r_wp      <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  state_t        r_es;
  state_t        w_es_nxt;
  logic [DW-1:0] r_ecnt;
  logic [DW-1:0] w_ecnt_nxt;
  logic          r_ent;
  logic          w_ent_nxt;
  logic          r_etag;
  logic          w_etag_nxt;
  logic          r_egate;
  logic          w_egate_nxt;
`ifdef PARKING_GATE_REJECT_EN
  logic          r_rej;
  logic          w_rej_nxt;
`endif

  always_comb begin
    w_es_nxt    = r_es;
    w_ecnt_nxt  = r_ecnt;
    w_ent_nxt   = 1'b0;
    w_etag_nxt  = 1'b0;
    w_egate_nxt = r_egate;
    w_pop       = 1'b0;
`ifdef PARKING_GATE_REJECT_EN
    w_rej_nxt   = 1'b0;
`endif
    unique case (r_es)
      S_IDLE: begin
        if (!w_empty && w_ok) begin
          w_pop       = 1'b1;
          w_es_nxt    = S_OPEN;
          w_ent_nxt   = 1'b1;
          w_etag_nxt  = w_head;
          w_egate_nxt = 1'b1;
          w_ecnt_nxt  = DWELL;
        end
`ifdef PARKING_GATE_REJECT_EN
        else if (!w_empty) begin
          w_pop     = 1'b1;
          w_rej_nxt = 1'b1;
        end
`endif
      end
      S_OPEN: begin
        if (r_ecnt == '0) begin
          w_egate_nxt = 1'b0;
          w_es_nxt    = S_IDLE;
        end else begin
          w_ecnt_nxt = r_ecnt - DW'(1);
        end
      end
      default: w_es_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_es    <= S_IDLE;
      r_ecnt  <= '0;
      r_ent   <= 1'b0;
      r_etag  <= 1'b0;
      r_egate <= 1'b0;
    end else begin
      r_es    <= w_es_nxt;
      r_ecnt  <= w_ecnt_nxt;
      r_ent   <= w_ent_nxt;
      r_etag  <= w_etag_nxt;
      r_egate <= w_egate_nxt;
    end
  end

`ifdef PARKING_GATE_REJECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rej <= 1'b0;
    end else begin
      r_rej <= w_rej_nxt;
    end
  end
`endif

  state_t        r_xs;
  state_t        w_xs_nxt;
  logic [DW-1:0] r_xcnt;
  logic [DW-1:0] w_xcnt_nxt;
  logic          r_ext;
  logic          w_ext_nxt;
  logic          r_xtag;
  logic          w_xtag_nxt;
  logic          r_xgate;
  logic          w_xgate_nxt;
  logic          r_xdrop;
  logic          w_xdrop_nxt;
  logic          r_pv;
  logic          w_pv_nxt;
  logic          r_pt;
  logic          w_pt_nxt;

  always_comb begin
    w_xs_nxt    = r_xs;
    w_xcnt_nxt  = r_xcnt;
    w_ext_nxt   = 1'b0;
    w_xtag_nxt  = 1'b0;
    w_xgate_nxt = r_xgate;
    w_xdrop_nxt = 1'b0;
    w_pv_nxt    = r_pv;
    w_pt_nxt    = r_pt;
    unique case (r_xs)
      S_IDLE: begin
        if (r_pv || bus.leave) begin
          w_xs_nxt    = S_OPEN;
          w_ext_nxt   = 1'b1;
          w_xgate_nxt = 1'b1;
          w_xcnt_nxt  = DWELL;
          w_xtag_nxt  = r_pv ? r_pt : bus.leave_uni;
          // pending goes first; a new leave refills the slot
          w_pv_nxt    = r_pv && bus.leave;
          if (bus.leave) begin
            w_pt_nxt = bus.leave_uni;
          end
        end
      end
      S_OPEN: begin
        if (bus.leave) begin
          if (r_pv) begin
            w_xdrop_nxt = 1'b1;
          end else begin
            w_pv_nxt = 1'b1;
            w_pt_nxt = bus.leave_uni;
          end
        end
        if (r_xcnt == '0) begin
          w_xgate_nxt = 1'b0;
          w_xs_nxt    = S_IDLE;
        end else begin
          w_xcnt_nxt = r_xcnt - DW'(1);
        end
      end
      default: w_xs_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs    <= S_IDLE;
      r_xcnt  <= '0;
      r_ext   <= 1'b0;
      r_xtag  <= 1'b0;
      r_xgate <= 1'b0;
      r_xdrop <= 1'b0;
      r_pv    <= 1'b0;
      r_pt    <= 1'b0;
    end else begin
      r_xs    <= w_xs_nxt;
      r_xcnt  <= w_xcnt_nxt;
      r_ext   <= w_ext_nxt;
      r_xtag  <= w_xtag_nxt;
      r_xgate <= w_xgate_nxt;
      r_xdrop <= w_xdrop_nxt;
      r_pv    <= w_pv_nxt;
      r_pt    <= w_pt_nxt;
    end
  end

  assign bus.car_entered       = r_ent;
  assign bus.is_uni_car_enterd = r_etag;
  assign bus.entry_gate_open   = r_egate;
  assign bus.car_exited        = r_ext;
  assign bus.is_uni_car_exited = r_xtag;
  assign bus.exit_gate_open    = r_xgate;
  assign bus.queue_count       = r_cnt;
  assign bus.queue_full        = (r_cnt == FULL);
  assign bus.arrive_drop       = r_adrop;
  assign bus.exit_drop         = r_xdrop;
`ifdef PARKING_GATE_REJECT_EN
  assign bus.rejected          = r_rej;
`else
  assign bus.rejected          = 1'b0;
`endif
endmodule

// File: tb/tb_parking_gate.sv
// tb_parking_gate: directed and random stimulus against a
// queue/timestamp model of the gate sequencer.
module tb_parking_gate;
  localparam int QD = 8;
  localparam int OC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  bit cu = 1'b0;
  bit co = 1'b0;

  always #5 clk = ~clk;

  parking_gate_if #(.QUEUE_DEPTH(QD)) bus ();

  parking_gate #(
    .QUEUE_DEPTH(QD),
    .OPEN_CYCLES(OC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic int tagword(input bit q[$]);
    int w = 0;
    foreach (q[i]) w = w * 2 + int'(q[i]);
    return w;
  endfunction

  // model: tag queue plus edge timestamps of last pulse per path
  bit mq[$];
  int k = 0;
  int e_last = -1000;
  int e_free = 0;
  int x_last = -1000;
  int x_free = 0;
  bit pv = 0;
  bit pt = 0;
  bit m_ent = 0, m_etag = 0, m_ext = 0, m_xtag = 0;
  bit m_adrop = 0, m_xdrop = 0, m_rej = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      k = 0;
      e_last = -1000;
      e_free = 0;
      x_last = -1000;
      x_free = 0;
      pv = 0;
      pt = 0;
      m_ent = 0; m_etag = 0; m_ext = 0; m_xtag = 0;
      m_adrop = 0; m_xdrop = 0; m_rej = 0;
    end else begin
      int sz;
      bit hd;
      bit ok;
      k++;
      sz = mq.size();
      m_ent = 0; m_etag = 0; m_rej = 0;
      m_ext = 0; m_xtag = 0; m_xdrop = 0;
      m_adrop = bus.arrive && (sz == QD);
      if (k >= e_free && sz > 0) begin
        hd = mq[0];
        ok = hd ? bus.uni_is_vacated_space : bus.is_vacated_space;
        if (ok) begin
          m_ent = 1;
          m_etag = hd;
          e_last = k;
          e_free = k + OC + 1;
          void'(mq.pop_front());
        end
`ifdef PARKING_GATE_REJECT_EN
        else begin
          m_rej = 1;
          void'(mq.pop_front());
        end
`endif
      end
      if (bus.arrive && sz < QD) mq.push_back(bus.arrive_uni);
      if (k >= x_free) begin
        if (pv) begin
          m_ext = 1;
          m_xtag = pt;
          x_last = k;
          x_free = k + OC + 1;
          pv = bus.leave;
          pt = bus.leave_uni;
        end else if (bus.leave) begin
          m_ext = 1;
          m_xtag = bus.leave_uni;
          x_last = k;
          x_free = k + OC + 1;
        end
      end else if (bus.leave) begin
        if (!pv) begin
          pv = 1;
          pt = bus.leave_uni;
        end else begin
          m_xdrop = 1;
        end
      end
    end
  end

  int n_ent, n_ext, n_adrop, n_xdrop, n_rej, n_egate, n_both;
  bit etags[$];
  bit xtags[$];

  always @(negedge clk) begin
    chk("car_entered", bus.car_entered, m_ent);
    chk("is_uni_car_enterd", bus.is_uni_car_enterd, m_etag);
    chk("car_exited", bus.car_exited, m_ext);
    chk("is_uni_car_exited", bus.is_uni_car_exited, m_xtag);
    chk("entry_gate_open", bus.entry_gate_open,
        int'((k - e_last) < OC));
    chk("exit_gate_open", bus.exit_gate_open,
        int'((k - x_last) < OC));
    chk("queue_count", bus.queue_count, mq.size());
    chk("queue_full", bus.queue_full, int'(mq.size() == QD));
    chk("arrive_drop", bus.arrive_drop, m_adrop);
    chk("exit_drop", bus.exit_drop, m_xdrop);
    chk("rejected", bus.rejected, m_rej);
    if (bus.car_entered) begin
      n_ent++;
      etags.push_back(bus.is_uni_car_enterd);
    end
    if (bus.car_exited) begin
      n_ext++;
      xtags.push_back(bus.is_uni_car_exited);
    end
    if (bus.car_entered && bus.car_exited) n_both++;
    if (bus.arrive_drop) n_adrop++;
    if (bus.exit_drop) n_xdrop++;
    if (bus.rejected) n_rej++;
    if (bus.entry_gate_open) n_egate++;
  end

  task automatic drive(input bit a, input bit au,
                       input bit l, input bit lu);
    @(negedge clk);
    bus.arrive = a;
    bus.arrive_uni = au;
    bus.leave = l;
    bus.leave_uni = lu;
    bus.uni_is_vacated_space = cu;
    bus.is_vacated_space = co;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic clr();
    #1;
    n_ent = 0; n_ext = 0; n_adrop = 0; n_xdrop = 0;
    n_rej = 0; n_egate = 0; n_both = 0;
    etags.delete();
    xtags.delete();
  endtask

  initial begin
    bus.arrive = 0;
    bus.arrive_uni = 0;
    bus.leave = 0;
    bus.leave_uni = 0;
    bus.uni_is_vacated_space = 0;
    bus.is_vacated_space = 0;
    rst_n = 0;
    repeat (3) drive(1, 1, 1, 1);
    drive(0, 0, 0, 0);
    rst_n = 1;
    clr();

    // single uni car
    cu = 1;
    co = 0;
    drive(1, 1, 0, 0);
    idle(10);
    #1;
    chk("p1_entered", n_ent, 1);
    chk("p1_tag", tagword(etags), 1);
    chk("p1_gate_cycles", n_egate, 4);
    chk("p1_qcount", bus.queue_count, 0);

    // overflow while ordinary vacancy is withheld
    clr();
    cu = 0;
    co = 0;
    repeat (10) drive(1, 0, 0, 0);
    idle(1);
    #1;
    chk("p2_full", bus.queue_full, 1);
    chk("p2_adrop", n_adrop, 2);
    co = 1;
    idle(45);
    #1;
    chk("p2_entered", n_ent, 8);
    chk("p2_qcount", bus.queue_count, 0);

    // head-of-line uni car without uni vacancy
    clr();
    cu = 0;
    co = 1;
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(8);
    #1;
`ifdef PARKING_GATE_REJECT_EN
    chk("p3_rejected", n_rej, 1);
    chk("p3_entered", n_ent, 2);
    chk("p3_tags", tagword(etags), 0);
    chk("p3_qcount", bus.queue_count, 0);
    cu = 1;
    idle(20);
`else
    chk("p3_blocked", n_ent, 0);
    chk("p3_qcount", bus.queue_count, 3);
    cu = 1;
    idle(20);
    #1;
    chk("p3_entered", n_ent, 3);
    chk("p3_tags", tagword(etags), 4);
`endif

    // exit pending/drop and simultaneous pulses
    clr();
    cu = 1;
    co = 1;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    idle(15);
    #1;
    chk("p4_exited", n_ext, 2);
    chk("p4_xtags", tagword(xtags), 2);
    chk("p4_xdrop", n_xdrop, 1);
    chk("p4_both", n_both, 1);

    // reset while both gates open and four cars wait
    clr();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 1);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    #1;
    chk("p5_pre_qcount", bus.queue_count, 4);
    chk("p5_pre_egate", bus.entry_gate_open, 1);
    chk("p5_pre_xgate", bus.exit_gate_open, 1);
    #1;
    rst_n = 0;
    #1;
    chk("p5_rst_egate", bus.entry_gate_open, 0);
    chk("p5_rst_xgate", bus.exit_gate_open, 0);
    chk("p5_rst_qcount", bus.queue_count, 0);
    idle(2);
    drive(0, 0, 0, 0);
    rst_n = 1;
    clr();
    idle(15);
    #1;
    chk("p5_post_entered", n_ent, 0);
    chk("p5_post_exited", n_ext, 0);

    // random traffic
    repeat (800) begin
      cu = ($urandom_range(0, 3) != 0);
      co = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    cu = 1;
    co = 1;
    idle(60);
    #1;
    chk("final_qcount", bus.queue_count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
